idelay_cal_ctrl: RTL and testbench

//  Sequencer for one source-synchronous DDR input lane's IDELAY tap. After reset or on start it

---
 rtl/idelay_cal_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_idelay_cal_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_cal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idelay_cal_ctrl : IDELAY tap sweep and eye-centre calibration sequencer. |
// | Optional MEASURE timeout built when IDELAY_CAL_TIMEOUT_EN is defined.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module idelay_cal_ctrl #(
  parameter int MAX_TAP       = 511,
  parameter int VTC_WAIT      = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 64,
  parameter int MIN_WINDOW    = 8,
  parameter int DEFAULT_TAP   = 0,
  parameter int TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rdy_idelay_i,
  input  logic       sample_valid_i,
  input  logic       sample_ok_i,
  output logic       delay_en_o,
  output logic       delay_inc_o,
  output logic       delay_en_vtc_o,
  output logic       delay_load_o,
  output logic [8:0] delay_cnt_value_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [8:0] eye_start_o,
  output logic [9:0] eye_width_o
);

  localparam int CW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_VTC_OFF, S_LOAD, S_SETTLE,
    S_MEASURE, S_STEP, S_APPLY, S_VTC_ON, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      tap_q, tap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   smp_q, smp_d;
  logic            err_q, err_d;
  logic [8:0]      cur_start_q, cur_start_d;
  logic [9:0]      cur_len_q, cur_len_d;
  logic [8:0]      best_start_q, best_start_d;
  logic [9:0]      best_len_q, best_len_d;
  logic            vtc_q, vtc_d;
  logic            load_q, load_d;
  logic [8:0]      value_q, value_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            success_q, success_d;
  logic [8:0]      eye_start_q, eye_start_d;
  logic [9:0]      eye_width_q, eye_width_d;

  logic            pass_w;
  logic [9:0]      run_len_w;
  logic [8:0]      run_start_w;
  logic [9:0]      centre_w;
  logic            win_ok_w;
  logic            sweep_w;
  logic            tmo_hit_w;

`ifdef IDELAY_CAL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_MEASURE && !sample_valid_i) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign tmo_hit_w = (tmo_q == TW'(TIMEOUT - 1)) && !sample_valid_i;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit_w      = 1'b0;
`endif

  // Run tracker result for the tap just measured; committed in STEP.
  assign pass_w      = !err_q;
  assign run_len_w   = pass_w ? cur_len_q + 10'd1 : 10'd0;
  assign run_start_w = (pass_w && cur_len_q == 10'd0) ? tap_q : cur_start_q;
  assign centre_w    = {1'b0, best_start_q} + (best_len_q >> 1);
  assign win_ok_w    = best_len_q >= 10'(MIN_WINDOW);
  assign sweep_w     = (state_q == S_VTC_OFF) || (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                       (state_q == S_MEASURE) || (state_q == S_STEP);

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    smp_d        = smp_q;
    err_d        = err_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    vtc_d        = vtc_q;
    load_d       = 1'b0;
    value_d      = value_q;
    done_d       = done_q;
    fail_d       = fail_q;
    success_d    = success_q;
    eye_start_d  = eye_start_q;
    eye_width_d  = eye_width_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_idelay_i) begin
          vtc_d        = 1'b0;
          cnt_d        = '0;
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          state_d      = S_VTC_OFF;
        end
      end
      S_VTC_OFF: begin
        if (cnt_q == CW'(VTC_WAIT - 1)) state_d = S_LOAD;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      S_LOAD: begin
        load_d  = 1'b1;
        value_d = tap_q;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          smp_d   = '0;
          err_d   = 1'b0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEASURE: begin
        if (sample_valid_i) begin
          smp_d = smp_q + CW'(1);
          if (!sample_ok_i) err_d = 1'b1;
          if (smp_q == CW'(SAMPLE_COUNT - 1)) state_d = S_STEP;
        end else if (tmo_hit_w) begin
          err_d   = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        cur_len_d   = run_len_w;
        cur_start_d = run_start_w;
        // Strict compare keeps the earliest of equally wide windows.
        if (run_len_w > best_len_q) begin
          best_len_d   = run_len_w;
          best_start_d = run_start_w;
        end
        if (tap_q == 9'(MAX_TAP)) begin
          state_d = S_APPLY;
        end else begin
          tap_d   = tap_q + 9'd1;
          state_d = S_LOAD;
        end
      end
      S_APPLY: begin
        load_d      = 1'b1;
        value_d     = win_ok_w ? centre_w[8:0] : 9'(DEFAULT_TAP);
        eye_start_d = best_start_q;
        eye_width_d = best_len_q;
        success_d   = win_ok_w;
        cnt_d       = '0;
        state_d     = S_VTC_ON;
      end
      S_VTC_ON: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          vtc_d   = 1'b1;
          done_d  = success_q;
          fail_d  = !success_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Losing the delay controller mid-sweep invalidates every score so far.
    if (sweep_w && !rdy_idelay_i) begin
      state_d      = S_WAIT_RDY;
      load_d       = 1'b0;
      value_d      = value_q;
      tap_d        = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_RDY;
      tap_q        <= '0;
      cnt_q        <= '0;
      smp_q        <= '0;
      err_q        <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      vtc_q        <= 1'b1;
      load_q       <= 1'b0;
      value_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      success_q    <= 1'b0;
      eye_start_q  <= '0;
      eye_width_q  <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      smp_q        <= smp_d;
      err_q        <= err_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      vtc_q        <= vtc_d;
      load_q       <= load_d;
      value_q      <= value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      success_q    <= success_d;
      eye_start_q  <= eye_start_d;
      eye_width_q  <= eye_width_d;
    end
  end

  assign delay_en_o        = 1'b0;
  assign delay_inc_o       = 1'b0;
  assign delay_en_vtc_o    = vtc_q;
  assign delay_load_o      = load_q;
  assign delay_cnt_value_o = value_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign fail_o            = fail_q;
  assign eye_start_o       = eye_start_q;
  assign eye_width_o       = eye_width_q;

endmodule
`default_nettype wire

// File: tb/tb_idelay_cal_ctrl.sv
`default_nettype none
// tb_idelay_cal_ctrl : randomized checker stimulus against a longest-passing-window
// reference model of the IDELAY calibration sequencer.
module tb_idelay_cal_ctrl;

  localparam int MAX_TAP  = 511;
  localparam int VTC_WAIT = 4;
  localparam int SETTLE   = 2;
  localparam int SAMPLES  = 4;
  localparam int MIN_WIN  = 8;
  localparam int DEF_TAP  = 7;
  localparam int TMO      = 16;
  localparam int BUDGET   = 30000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rdy = 1'b1;
  logic       sv = 1'b0;
  logic       sok = 1'b0;
  logic       delay_en, delay_inc, en_vtc, delay_load, busy, done, fail;
  logic [8:0] cnt_value, eye_start;
  logic [9:0] eye_width;

  idelay_cal_ctrl #(
    .MAX_TAP(MAX_TAP), .VTC_WAIT(VTC_WAIT), .SETTLE_CYCLES(SETTLE),
    .SAMPLE_COUNT(SAMPLES), .MIN_WINDOW(MIN_WIN), .DEFAULT_TAP(DEF_TAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .rdy_idelay_i(rdy),
    .sample_valid_i(sv), .sample_ok_i(sok),
    .delay_en_o(delay_en), .delay_inc_o(delay_inc), .delay_en_vtc_o(en_vtc),
    .delay_load_o(delay_load), .delay_cnt_value_o(cnt_value),
    .busy_o(busy), .done_o(done), .fail_o(fail),
    .eye_start_o(eye_start), .eye_width_o(eye_width)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit pass_map [0:MAX_TAP];
  bit stuck_low = 1'b0;
  int cur_tap = 0;
  int sweep_idx = 0;    // next expected sweep tap; MAX_TAP+1 means final load expected
  int exp_final = 0;
  bit final_seen = 1'b0;
  int vtc_low = 0;
  bit prev_load = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: longest run of passing taps, earliest on ties.
  function automatic void best_window(output int bs, output int bw);
    int s;
    bit p;
    bs = 0; bw = 0; s = -1;
    for (int t = 0; t <= MAX_TAP + 1; t++) begin
      p = (t <= MAX_TAP) ? pass_map[t] : 1'b0;
      if (p && s < 0) s = t;
      if (!p && s >= 0) begin
        if (t - s > bw) begin bw = t - s; bs = s; end
        s = -1;
      end
    end
  endfunction

  // Per-cycle compare of strobes and load sequence; also plays the pattern checker.
  always @(negedge clk) begin
    if (rst) begin
      sweep_idx  = 0;
      final_seen = 1'b0;
      prev_load  = 1'b0;
      vtc_low    = 0;
    end else begin
      chk("delay_en", delay_en, 0);
      chk("delay_inc", delay_inc, 0);
      if (delay_load) begin
        chk("load_width", prev_load, 0);
        if (sweep_idx <= MAX_TAP) begin
          if (sweep_idx == 0) chk("vtc_low_before_first_load_ge", int'(vtc_low >= VTC_WAIT), 1);
          chk("sweep_tap", cnt_value, sweep_idx);
          sweep_idx++;
        end else if (sweep_idx == MAX_TAP + 1) begin
          chk("final_tap", cnt_value, exp_final);
          final_seen = 1'b1;
          sweep_idx++;
        end else begin
          checks++;
          failures++;
          $display("FAIL extra_load actual=%0d required=no_load", cnt_value);
        end
        cur_tap = cnt_value;
      end
      if (!rdy && busy) sweep_idx = 0;
      vtc_low   = en_vtc ? 0 : vtc_low + 1;
      prev_load = delay_load;
    end
    #1;
    sv  = stuck_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    sok = sv ? pass_map[cur_tap] : 1'($urandom_range(0, 1));
  end

  task automatic set_windows(input int s0, input int l0, input int s1, input int l1);
    for (int t = 0; t <= MAX_TAP; t++)
      pass_map[t] = ((t >= s0) && (t < s0 + l0)) || ((t >= s1) && (t < s1 + l1));
  endtask

  // mode: 0 plain, 1 drop rdy after tap 'at' loads, 2 pulse start after tap 'at' loads
  task automatic run_cal(input string name, input bit use_lit, input int ls, input int lw,
                         input int lf, input int lok, input bit use_reset,
                         input int mode, input int at);
    int bs, bw, ef, cyc;
    bit ok, hit;
    best_window(bs, bw);
    ok = (bw >= MIN_WIN);
    ef = ok ? bs + bw / 2 : DEF_TAP;
    if (use_lit) begin
      chk({name, ":model_start"}, bs, ls);
      chk({name, ":model_width"}, bw, lw);
      chk({name, ":model_final"}, ef, lf);
      chk({name, ":model_ok"}, int'(ok), lok);
    end
    @(negedge clk); #1;
    exp_final  = ef;
    final_seen = 1'b0;
    sweep_idx  = 0;
    if (use_reset) begin
      rst = 1'b1;
      @(negedge clk);
      chk({name, ":rst_load"}, delay_load, 0);
      chk({name, ":rst_busy"}, busy, 0);
      chk({name, ":rst_en_vtc"}, en_vtc, 1);
      chk({name, ":rst_cnt"}, cnt_value, 0);
      #1 rst = 1'b0;
    end else begin
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    if (mode != 0) begin
      hit = 1'b0;
      for (cyc = 0; cyc < BUDGET && !hit; cyc++) begin
        @(negedge clk);
        hit = delay_load && (cnt_value == 9'(at));
      end
      chk({name, ":reached_tap"}, int'(hit), 1);
      repeat (3) @(negedge clk);
      #1;
      if (mode == 1) begin
        rdy = 1'b0;
        repeat (20) @(negedge clk);
        chk({name, ":abort_en_vtc"}, en_vtc, 0);
        chk({name, ":abort_busy"}, busy, 1);
        #1 rdy = 1'b1;
      end else begin
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
      end
    end
    hit = 1'b0;
    for (cyc = 0; cyc < BUDGET && !hit; cyc++) begin
      @(negedge clk);
      hit = done || fail;
    end
    chk({name, ":finished_in_budget"}, int'(hit), 1);
    chk({name, ":done"}, done, int'(ok));
    chk({name, ":fail"}, fail, int'(!ok));
    chk({name, ":eye_start"}, eye_start, bs);
    chk({name, ":eye_width"}, eye_width, bw);
    chk({name, ":en_vtc"}, en_vtc, 1);
    chk({name, ":busy"}, busy, 0);
    chk({name, ":final_load_seen"}, final_seen, 1);
    chk({name, ":cnt_value_held"}, cnt_value, ef);
    @(negedge clk);
    chk({name, ":done_held"}, done, int'(ok));
    chk({name, ":fail_held"}, fail, int'(!ok));
  endtask

  initial begin
    set_windows(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset:en_vtc", en_vtc, 1);
    chk("reset:load", delay_load, 0);
    chk("reset:cnt_value", cnt_value, 0);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:fail", fail, 0);
    chk("reset:eye_start", eye_start, 0);
    chk("reset:eye_width", eye_width, 0);
    #1 rst = 1'b0;
    repeat (300) @(negedge clk);   // reset below lands mid-sweep

    set_windows(100, 40, 0, 0);
    run_cal("win100", 1'b1, 100, 40, 120, 1, 1'b1, 0, 0);
    set_windows(10, 20, 300, 30);
    run_cal("longer", 1'b1, 300, 30, 315, 1, 1'b0, 0, 0);
    set_windows(50, 10, 200, 10);
    run_cal("tie_start_ignored", 1'b1, 50, 10, 55, 1, 1'b0, 2, 100);
    set_windows(0, 0, 0, 0);
    run_cal("all_fail", 1'b1, 0, 0, DEF_TAP, 0, 1'b0, 0, 0);
    set_windows(40, 5, 0, 0);
    run_cal("narrow", 1'b1, 40, 5, DEF_TAP, 0, 1'b0, 0, 0);
    set_windows(500, 12, 0, 0);
    run_cal("edge", 1'b1, 500, 12, 506, 1, 1'b0, 0, 0);
    set_windows(100, 40, 0, 0);
    run_cal("rdy_drop", 1'b1, 100, 40, 120, 1, 1'b0, 1, 200);

    for (int t = 0; t <= MAX_TAP; t++) pass_map[t] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int s, l;
      s = $urandom_range(0, MAX_TAP);
      l = $urandom_range(1, 60);
      for (int t = s; t < s + l && t <= MAX_TAP; t++) pass_map[t] = 1'b1;
    end
    run_cal("random", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);

`ifdef IDELAY_CAL_TIMEOUT_EN
    set_windows(0, 0, 0, 0);
    stuck_low = 1'b1;
    run_cal("timeout", 1'b1, 0, 0, DEF_TAP, 0, 1'b0, 0, 0);
    stuck_low = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
